// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_NEG  = 3'b000,
      OP_INC  = 3'b001,
      OP_DBL  = 3'b010,
      OP_HADD = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_CAT  = 3'b110,
      OP_MUL  = 3'b111
   } opc_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle of alu_seq. Optional flag outputs exist
// only when ALU_FLAGS_EN is defined.
interface alu_seq_if #(parameter int WIDTH = 16);
   import alu_seq_pkg::*;

   logic             in_valid;
   logic             in_ready;
   opc_t             opc;
   logic [WIDTH-1:0] ina;
   logic [WIDTH-1:0] inb;
   logic             inc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] w;
   logic             zer;
   logic             neg;
   logic             busy;
`ifdef ALU_FLAGS_EN
   logic             cout;
   logic             ovf;
`endif

   modport master (
      output in_valid, opc, ina, inb, inc, out_ready,
      input  in_ready, out_valid, w, zer, neg, busy
`ifdef ALU_FLAGS_EN
      , input cout, ovf
`endif
   );

   modport slave (
      input  in_valid, opc, ina, inb, inc, out_ready,
      output in_ready, out_valid, w, zer, neg, busy
`ifdef ALU_FLAGS_EN
      , output cout, ovf
`endif
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle for exactly WIDTH cycles.
// prod_o is the accumulator value after the current iteration, valid with done_o.
module alu_mul_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1,
   parameter int ACC_W = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [ACC_W-1:0] prod_o
);

   logic [ACC_W-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;

   always_comb begin
      acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      done_o = run_q & (cnt_q == CNT_W'(WIDTH - 1));
      prod_o = acc_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= ACC_W'(a_i);
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b1;
      end else if (run_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CNT_W'(1);
         if (done_o) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a multi-cycle multiply.
// Define ALU_FLAGS_EN to add the cout/ovf flag outputs.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_seq_if.slave    bus
);

`ifdef ALU_FLAGS_EN
   localparam int ACC_W = 2 * WIDTH;
   localparam int RW    = WIDTH + 1;
`else
   localparam int ACC_W = WIDTH;
   localparam int RW    = WIDTH;
`endif

   state_t           state_q, state_d;
   logic             in_ready_s, out_valid_s, busy_s;
   logic             accept, is_mul, load_alu, load_mul;
   logic             mul_done;
   logic [ACC_W-1:0] mul_prod;
   logic [RW-1:0]    alu_r;
   logic [WIDTH-1:0] res_s;
   logic [WIDTH-1:0] w_q, w_d;
   logic             zer_q, zer_d, neg_q, neg_d;
`ifdef ALU_FLAGS_EN
   logic             cout_q, cout_d, ovf_q, ovf_d;
`endif

   // Result with carry out of the MSB appended when the flag outputs exist.
   function automatic logic [RW-1:0] alu_f(opc_t op, logic [WIDTH-1:0] a,
                                           logic [WIDTH-1:0] b, logic c);
      logic [WIDTH:0] ext;
      case (op)
         OP_NEG:  ext = {1'b0, ~a} + (WIDTH+1)'(1);
         OP_INC:  ext = {1'b0, a} + (WIDTH+1)'(1);
         OP_DBL:  ext = {1'b0, a} + {1'b0, a} + (WIDTH+1)'(c);
         OP_HADD: ext = {1'b0, a} + {2'b00, b[WIDTH-1:1]};
         OP_AND:  ext = {1'b0, a & b};
         OP_OR:   ext = {1'b0, a | b};
         OP_CAT:  ext = {1'b0, a[WIDTH/2-1:0], b[WIDTH/2-1:0]};
         default: ext = '0;
      endcase
      return ext[RW-1:0];
   endfunction

`ifdef ALU_FLAGS_EN
   function automatic logic ovf_f(opc_t op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] r);
      case (op)
         OP_NEG:  return a == {1'b1, {(WIDTH-1){1'b0}}};
         OP_INC:  return ~a[WIDTH-1] & r[WIDTH-1];
         OP_DBL:  return a[WIDTH-1] ^ r[WIDTH-1];
         OP_HADD: return ~a[WIDTH-1] & r[WIDTH-1];
         default: return 1'b0;
      endcase
   endfunction
`endif

   assign accept   = bus.in_valid & in_ready_s;
   assign is_mul   = (bus.opc == OP_MUL);
   assign load_alu = accept & ~is_mul;
   assign load_mul = (state_q == MUL) & mul_done;

   alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (accept & is_mul),
      .a_i     (bus.ina),
      .b_i     (bus.inb),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = is_mul ? MUL : DONE;
         MUL:  if (mul_done) state_d = DONE;
         DONE: begin
            if (accept)             state_d = is_mul ? MUL : DONE;
            else if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_s  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
      out_valid_s = (state_q == DONE);
      busy_s      = (state_q == MUL);
   end

   // Flags are derived from the value being written so they always match w.
   always_comb begin
      alu_r = alu_f(bus.opc, bus.ina, bus.inb, bus.inc);
      res_s = '0;
      w_d   = w_q;
      zer_d = zer_q;
      neg_d = neg_q;
`ifdef ALU_FLAGS_EN
      cout_d = cout_q;
      ovf_d  = ovf_q;
`endif
      if (load_alu) begin
         res_s = alu_r[WIDTH-1:0];
         w_d   = res_s;
         zer_d = (res_s == '0);
         neg_d = res_s[WIDTH-1];
`ifdef ALU_FLAGS_EN
         cout_d = alu_r[WIDTH];
         ovf_d  = ovf_f(bus.opc, bus.ina, res_s);
`endif
      end else if (load_mul) begin
         res_s = mul_prod[WIDTH-1:0];
         w_d   = res_s;
         zer_d = (res_s == '0);
         neg_d = res_s[WIDTH-1];
`ifdef ALU_FLAGS_EN
         cout_d = 1'b0;
         ovf_d  = |mul_prod[ACC_W-1:WIDTH];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q   <= '0;
         zer_q <= 1'b0;
         neg_q <= 1'b0;
`ifdef ALU_FLAGS_EN
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
`endif
      end else begin
         w_q   <= w_d;
         zer_q <= zer_d;
         neg_q <= neg_d;
`ifdef ALU_FLAGS_EN
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.busy      = busy_s;
   assign bus.w         = w_q;
   assign bus.zer       = zer_q;
   assign bus.neg       = neg_q;
`ifdef ALU_FLAGS_EN
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table plus handshake, multiply-timing
// and reset corner-case sequences.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   alu_seq_if #(.WIDTH(W)) bus();

   alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      opc_t        opc;
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [15:0] w;
      logic        zer;
      logic        neg;
      logic        cout;
      logic        ovf;
      int          lat;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input opc_t op, input logic [15:0] a, input logic [15:0] b, input logic c);
      bus.opc = op;
      bus.ina = a;
      bus.inb = b;
      bus.inc = c;
   endtask

   task automatic run_vec(input int i);
      int lat;
      @(negedge clk);
      drive(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].c);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      chk($sformatf("vec%0d in_ready", i), bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 40);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d w", i), bus.w, vecs[i].w);
      chk($sformatf("vec%0d zer", i), bus.zer, vecs[i].zer);
      chk($sformatf("vec%0d neg", i), bus.neg, vecs[i].neg);
`ifdef ALU_FLAGS_EN
      chk($sformatf("vec%0d cout", i), bus.cout, vecs[i].cout);
      chk($sformatf("vec%0d ovf", i), bus.ovf, vecs[i].ovf);
`endif
   endtask

   initial begin
      int lat;
      int bcnt;
      logic [15:0] tp_exp[4];

      //            opc      a        b        c     w        z     n     cout  ovf   lat
      vecs[0]  = '{OP_NEG,  16'h0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[1]  = '{OP_NEG,  16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
      vecs[2]  = '{OP_HADD, 16'h0010, 16'h0007, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[3]  = '{OP_CAT,  16'h12AB, 16'h34CD, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[4]  = '{OP_DBL,  16'h8000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1};
      vecs[5]  = '{OP_INC,  16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
      vecs[6]  = '{OP_INC,  16'h7FFF, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
      vecs[7]  = '{OP_OR,   16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{OP_NEG,  16'h8000, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
      vecs[9]  = '{OP_HADD, 16'hFFFF, 16'hFFFF, 1'b0, 16'h7FFE, 1'b0, 1'b0, 1'b1, 1'b0, 1};
      vecs[10] = '{OP_DBL,  16'h4000, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
      vecs[11] = '{OP_CAT,  16'hFFFF, 16'h0000, 1'b0, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[12] = '{OP_MUL,  16'h0012, 16'h0034, 1'b0, 16'h03A8, 1'b0, 1'b0, 1'b0, 1'b0, 17};
      vecs[13] = '{OP_MUL,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 17};
      vecs[14] = '{OP_MUL,  16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 17};
      vecs[15] = '{OP_AND,  16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0, 1};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(OP_NEG, 16'h0000, 16'h0000, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst w", bus.w, 0);
      chk("rst zer", bus.zer, 0);
      chk("rst neg", bus.neg, 0);
      chk("rst in_ready", bus.in_ready, 1);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(i);

      // Multiply timing; in_valid held with another op must be ignored while busy
      @(negedge clk);
      drive(OP_MUL, 16'h0012, 16'h0034, 1'b0);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 drive(OP_AND, 16'hFFFF, 16'hFFFF, 1'b0);
      lat  = 0;
      bcnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.busy && !bus.in_ready) bcnt++;
      end while (!bus.out_valid && lat < 40);
      bus.in_valid = 1'b0;
      chk("mul latency", lat, 17);
      chk("mul busy cycles", bcnt, 16);
      chk("mul w", bus.w, 16'h03A8);
      @(negedge clk);
      chk("mul no extra accept", bus.out_valid, 0);

      // Back-pressure on an OR result
      drive(OP_OR, 16'h1200, 16'h0034, 1'b0);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      drive(OP_NEG, 16'h0005, 16'h0000, 1'b0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d out_valid", k), bus.out_valid, 1);
         chk($sformatf("bp%0d w", k), bus.w, 16'h1234);
         chk($sformatf("bp%0d zer_neg", k), {bus.zer, bus.neg}, 2'b00);
         chk($sformatf("bp%0d in_ready", k), bus.in_ready, 0);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp released", bus.out_valid, 0);

      // Four back-to-back increments
      for (int i = 0; i < 4; i++) tp_exp[i] = 16'((i + 1) * 16 + 1);
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) begin
            chk($sformatf("tp%0d out_valid", i - 1), bus.out_valid, 1);
            chk($sformatf("tp%0d w", i - 1), bus.w, tp_exp[i - 1]);
         end
         if (i < 4) begin
            drive(OP_INC, 16'((i + 1) * 16), 16'h0000, 1'b0);
            bus.in_valid = 1'b1;
            chk($sformatf("tp%0d in_ready", i), bus.in_ready, 1);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
      end

      // Reset in the middle of a multiply
      drive(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrst busy before", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", bus.out_valid, 0);
      chk("midrst w", bus.w, 0);
      chk("midrst busy", bus.busy, 0);
      chk("midrst zer_neg", {bus.zer, bus.neg}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
